// File: rtl/player_sprite_fetch.sv
// -----------------------------------------------------------------------------
// player_sprite_fetch
//
// Front end of the per-pixel compositor for the player sprite. For every scan
// position it decides whether the pixel lies inside the player's bounding box,
// builds the sprite ROM address and returns a registered palette index. The
// player animation state machine lives here too, so that the ROM frame offset
// and the mirroring bit change only on video frame boundaries.
//
// Pipeline (DrawX/DrawY presented in cycle N):
//   stage 1 (end of N)   : box test, romAddr registered        -> visible N+1
//   stage 2 (end of N+1) : inside flag delayed while ROM reads  -> visible N+2
//   stage 3 (end of N+2) : playerOn / playerPixel registered    -> visible N+3
//
// Ports:
//   Clk          system clock
//   Reset        asynchronous, active-high
//   DrawX/DrawY  current scan column / row (10 bits)
//   PlayerX/Y    sprite top-left corner (10 bits)
//   frameStart   one-cycle pulse per video frame
//   moving       player run request
//   facingLeft   1 = horizontally mirrored sprite (latched on frameStart)
//   romData      sprite ROM read data, valid one cycle after romAddr
//   romAddr      sprite ROM address
//   playerOn     pixel lies inside the sprite box (3-cycle latency)
//   playerPixel  ROM colour index, or TRANSPARENT outside the box
//   animFrame    current animation frame (0 = idle pose, 1..NUM_RUN = run)
// -----------------------------------------------------------------------------
module player_sprite_fetch #(
  parameter int         SPR_W       = 32,
  parameter int         SPR_H       = 32,
  parameter int         NUM_RUN     = 6,
  parameter int         FRAME_HOLD  = 4,
  parameter int         ADDR_W      = 13,
  parameter logic [4:0] TRANSPARENT = 5'h15
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        PlayerX,
  input  logic [9:0]        PlayerY,
  input  logic              frameStart,
  input  logic              moving,
  input  logic              facingLeft,
  input  logic [4:0]        romData,
  output logic [ADDR_W-1:0] romAddr,
  output logic              playerOn,
  output logic [4:0]        playerPixel,
  output logic [2:0]        animFrame
);

  localparam int COL_W  = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Animation state
  // ---------------------------------------------------------------------------
  state_t            state_q;
  logic [2:0]        anim_q;
  logic [HOLD_W-1:0] hold_q;
  logic              facing_q;

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  logic              vld_p1_q;
  logic [ADDR_W-1:0] addr_p1_q;
  logic              vld_p2_q;
  logic              on_p3_q;
  logic [4:0]        pix_p3_q;

  // Stage-1 combinational signals
  logic [10:0]       draw_x_ext;
  logic [10:0]       draw_y_ext;
  logic [10:0]       box_x_lo;
  logic [10:0]       box_y_lo;
  logic [10:0]       box_x_hi;
  logic [10:0]       box_y_hi;
  logic              inside_d;
  logic [COL_W-1:0]  col_fwd;
  logic [COL_W-1:0]  col_sel;
  logic [ADDR_W-1:0] row_off;
  logic [ADDR_W-1:0] addr_d;

  // Linear ROM layout: frames stacked back to back, rows of SPR_W pixels.
  function automatic logic [ADDR_W-1:0] sprite_addr(
    input logic [2:0]        frame,
    input logic [ADDR_W-1:0] row,
    input logic [COL_W-1:0]  col
  );
    sprite_addr = ADDR_W'(frame) * ADDR_W'(SPR_W * SPR_H)
                + row * ADDR_W'(SPR_W)
                + ADDR_W'(col);
  endfunction

  // ---------------------------------------------------------------------------
  // Animation FSM: advances only on frameStart so the sprite never changes in
  // the middle of a displayed frame. holdCnt paces each run frame.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      anim_q   <= 3'd0;
      hold_q   <= '0;
      facing_q <= 1'b0;
    end else if (frameStart) begin
      facing_q <= facingLeft;
      case (state_q)
        IDLE: begin
          hold_q <= '0;
          if (moving) begin
            state_q <= RUN;
            anim_q  <= 3'd1;
          end else begin
            anim_q  <= 3'd0;
          end
        end
        RUN: begin
          if (!moving) begin
            // Stop immediately; the run cycle is not played to completion.
            state_q <= IDLE;
            anim_q  <= 3'd0;
            hold_q  <= '0;
          end else if (hold_q == HOLD_W'(FRAME_HOLD - 1)) begin
            hold_q <= '0;
            // Run frames cycle 1..NUM_RUN; frame 0 is reserved for idle.
            if (anim_q == 3'(NUM_RUN)) begin
              anim_q <= 3'd1;
            end else begin
              anim_q <= anim_q + 3'd1;
            end
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          anim_q  <= 3'd0;
          hold_q  <= '0;
        end
      endcase
    end
  end

  // Box limits are formed at 11 bits so a sprite near column/row 1023 cannot
  // wrap its right/bottom edge back into column/row 0.
  assign draw_x_ext = {1'b0, DrawX};
  assign draw_y_ext = {1'b0, DrawY};
  assign box_x_lo   = {1'b0, PlayerX};
  assign box_y_lo   = {1'b0, PlayerY};
  assign box_x_hi   = box_x_lo + 11'(SPR_W);
  assign box_y_hi   = box_y_lo + 11'(SPR_H);

  assign inside_d = (draw_x_ext >= box_x_lo) && (draw_x_ext < box_x_hi) &&
                    (draw_y_ext >= box_y_lo) && (draw_y_ext < box_y_hi);

  // Only the low COL_W bits of the column offset matter inside the box.
  assign col_fwd = COL_W'(DrawX - PlayerX);
  assign col_sel = facing_q ? (COL_W'(SPR_W - 1) - col_fwd) : col_fwd;
  assign row_off = ADDR_W'(DrawY - PlayerY);

  // Hold the last address outside the box to avoid needless ROM activity.
  assign addr_d = inside_d ? sprite_addr(anim_q, row_off, col_sel) : addr_p1_q;

  // ---------------------------------------------------------------------------
  // Stage 1: box test and ROM address
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vld_p1_q  <= 1'b0;
      addr_p1_q <= '0;
    end else begin
      vld_p1_q  <= inside_d;
      addr_p1_q <= addr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: inside flag waits for the synchronous ROM read
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vld_p2_q <= 1'b0;
    end else begin
      vld_p2_q <= vld_p1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: output register, flag and colour aligned
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      on_p3_q  <= 1'b0;
      pix_p3_q <= TRANSPARENT;
    end else begin
      on_p3_q  <= vld_p2_q;
      pix_p3_q <= vld_p2_q ? romData : TRANSPARENT;
    end
  end

  assign romAddr     = addr_p1_q;
  assign playerOn    = on_p3_q;
  assign playerPixel = pix_p3_q;
  assign animFrame   = anim_q;

endmodule
